// File: rtl/div_unit.sv
// Multi-cycle 32-bit restoring divider for DIV/DIVU.
// Returns {remainder, quotient} with a ready flag that releases the execute-stage stall.
module div_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o
);

    typedef enum logic [1:0] {
        FREE,
        BYZERO,
        ON,
        END
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [64:0] work_q, work_d;
    logic [31:0] dvsrAbs_q, dvsrAbs_d;
    logic        negQuo_q, negQuo_d;
    logic        negRem_q, negRem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    logic [31:0] dvndAbs;
    logic [31:0] dvsrAbs;
    logic [31:0] remFinal;
    logic [31:0] quoFinal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FREE;
            cnt_q     <= 6'd0;
            work_q    <= 65'd0;
            dvsrAbs_q <= 32'd0;
            negQuo_q  <= 1'b0;
            negRem_q  <= 1'b0;
            result_q  <= 64'h0;
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            work_q    <= work_d;
            dvsrAbs_q <= dvsrAbs_d;
            negQuo_q  <= negQuo_d;
            negRem_q  <= negRem_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        work_d    = work_q;
        dvsrAbs_d = dvsrAbs_q;
        negQuo_d  = negQuo_q;
        negRem_d  = negRem_q;
        result_d  = result_q;
        ready_d   = ready_q;

        dvndAbs  = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
        dvsrAbs  = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
        remFinal = negRem_q ? (32'd0 - work_q[63:32]) : work_q[63:32];
        quoFinal = negQuo_q ? (32'd0 - work_q[31:0]) : work_q[31:0];

        // A flush wins over everything else, including a fresh request in FREE.
        if (annul_i) begin
            state_d  = FREE;
            cnt_d    = 6'd0;
            result_d = 64'h0;
            ready_d  = 1'b0;
        end else begin
            case (state_q)
                FREE: begin
                    result_d = 64'h0;
                    ready_d  = 1'b0;
                    if (start_i) begin
                        if (opdata2_i == 32'd0) begin
                            state_d = BYZERO;
                        end else begin
                            state_d   = ON;
                            cnt_d     = 6'd0;
                            work_d    = {33'd0, dvndAbs};
                            dvsrAbs_d = dvsrAbs;
                            negQuo_d  = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
                            negRem_d  = signed_div_i & opdata1_i[31];
                        end
                    end
                end
                BYZERO: begin
                    state_d  = END;
                    result_d = 64'h0;
                    ready_d  = 1'b1;
                end
                ON: begin
                    if (cnt_q != 6'd32) begin
                        // Shift in the next dividend bit, then keep the trial subtraction if it did not borrow.
                        work_d = work_q << 1;
                        if (work_d[64:32] >= {1'b0, dvsrAbs_q}) begin
                            work_d[64:32] = work_d[64:32] - {1'b0, dvsrAbs_q};
                            work_d[0]     = 1'b1;
                        end
                        cnt_d = cnt_q + 6'd1;
                    end else begin
                        state_d  = END;
                        result_d = {remFinal, quoFinal};
                        ready_d  = 1'b1;
                    end
                end
                END: begin
                    if (!start_i) begin
                        state_d  = FREE;
                        result_d = 64'h0;
                        ready_d  = 1'b0;
                    end
                end
                default: begin
                    state_d  = FREE;
                    result_d = 64'h0;
                    ready_d  = 1'b0;
                end
            endcase
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: a magnitude-arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;

    int assertCount = 0;
    int failCount   = 0;
    bit chkEn       = 1'b0;

    div_unit dut (
        .clk         (clk),
        .rst         (rst),
        .signed_div_i(signed_div_i),
        .opdata1_i   (opdata1_i),
        .opdata2_i   (opdata2_i),
        .start_i     (start_i),
        .annul_i     (annul_i),
        .result_o    (result_o),
        .ready_o     (ready_o)
    );

    always #5 clk = ~clk;

    // Reference divide on 64-bit magnitudes: truncate toward zero, remainder takes the dividend's sign.
    function automatic logic [63:0] modelDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ma, mb, q, r;
        logic [31:0] q32, r32;
        if (b == 32'd0) return 64'h0;
        ma  = (sgn && a[31]) ? (64'h1_0000_0000 - {32'h0, a}) : {32'h0, a};
        mb  = (sgn && b[31]) ? (64'h1_0000_0000 - {32'h0, b}) : {32'h0, b};
        q   = ma / mb;
        r   = ma % mb;
        q32 = q[31:0];
        r32 = r[31:0];
        if (sgn && (a[31] ^ b[31])) q32 = 32'd0 - q32;
        if (sgn && a[31]) r32 = 32'd0 - r32;
        return {r32, q32};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        assertCount++;
        if (act !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Transaction-level timing model: idle -> busy for a fixed latency -> done until start drops.
    int          phase;
    int          left;
    logic [63:0] pend;
    logic        expReady;
    logic [63:0] expResult;

    always @(posedge clk) begin
        if (rst) begin
            phase     <= 0;
            left      <= 0;
            expReady  <= 1'b0;
            expResult <= 64'h0;
        end else if (annul_i) begin
            phase     <= 0;
            expReady  <= 1'b0;
            expResult <= 64'h0;
        end else begin
            case (phase)
                0: if (start_i) begin
                    pend  <= modelDiv(signed_div_i, opdata1_i, opdata2_i);
                    left  <= (opdata2_i == 32'd0) ? 1 : 33;
                    phase <= 1;
                end
                1: if (left == 1) begin
                    expReady  <= 1'b1;
                    expResult <= pend;
                    phase     <= 2;
                end else begin
                    left <= left - 1;
                end
                default: if (!start_i) begin
                    expReady  <= 1'b0;
                    expResult <= 64'h0;
                    phase     <= 0;
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (chkEn) begin
            checkOutput("cyc_ready", {63'b0, ready_o}, {63'b0, expReady});
            checkOutput("cyc_result", result_o, expResult);
        end
    end

    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        signed_div_i = sgn;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
    endtask

    // Called just after applyStimulus; the first edge is the sampling edge E0.
    task automatic waitReady(input string name, input int expLat, input logic [63:0] expRes, input bit scramble);
        int lat  = 0;
        bit seen = 1'b0;
        @(posedge clk);
        for (int i = 1; i <= 60 && !seen; i++) begin
            if (scramble) begin
                #1;
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
            lat = i;
            if (ready_o) seen = 1'b1;
        end
        checkOutput({name, "_latency"}, 64'(lat), 64'(expLat));
        checkOutput({name, "_result"}, result_o, expRes);
    endtask

    task automatic releaseStart(input string name);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput({name, "_drop_ready"}, {63'b0, ready_o}, 64'h0);
        checkOutput({name, "_drop_result"}, result_o, 64'h0);
    endtask

    typedef struct {
        logic        sgn;
        logic [31:0] a;
        logic [31:0] b;
        int          lat;
        logic [63:0] res;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{1'b1, 32'hFFFFFFF9, 32'h00000002, 33, 64'hFFFFFFFF_FFFFFFFD};
        vecs[1] = '{1'b1, 32'h00000007, 32'hFFFFFFFE, 33, 64'h00000001_FFFFFFFD};
        vecs[2] = '{1'b0, 32'h0000007B, 32'h00000000, 1,  64'h00000000_00000000};
        vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'h00000001, 33, 64'h00000000_FFFFFFFF};
        vecs[4] = '{1'b1, 32'h80000000, 32'hFFFFFFFF, 33, 64'h00000000_80000000};
        vecs[5] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 64'h00000000_00000001};

        rst          = 1'b1;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;

        checkOutput("pin_u100_7", modelDiv(1'b0, 32'd100, 32'd7), 64'h00000002_0000000E);
        checkOutput("pin_s_m7_2", modelDiv(1'b1, 32'hFFFFFFF9, 32'd2), 64'hFFFFFFFF_FFFFFFFD);
        checkOutput("pin_s_7_m2", modelDiv(1'b1, 32'd7, 32'hFFFFFFFE), 64'h00000001_FFFFFFFD);
        checkOutput("pin_s_min_m1", modelDiv(1'b1, 32'h80000000, 32'hFFFFFFFF), 64'h00000000_80000000);
        checkOutput("pin_u_bigneg", modelDiv(1'b0, 32'hFFFFFFF9, 32'd2), 64'h00000001_7FFFFFFC);

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_ready", {63'b0, ready_o}, 64'h0);
        checkOutput("reset_result", result_o, 64'h0);
        rst   = 1'b0;
        chkEn = 1'b1;

        applyStimulus(1'b0, 32'd100, 32'd7);
        waitReady("u100_7", 33, 64'h00000002_0000000E, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            checkOutput("u100_7_hold", result_o, 64'h00000002_0000000E);
        end
        releaseStart("u100_7");

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].sgn, vecs[i].a, vecs[i].b);
            waitReady($sformatf("vec%0d", i), vecs[i].lat, vecs[i].res, 1'b0);
            releaseStart($sformatf("vec%0d", i));
        end

        // Flush ten iterations into an operation, then restart two cycles later.
        applyStimulus(1'b0, 32'd1000, 32'd3);
        @(posedge clk);
        repeat (10) @(posedge clk);
        #1;
        annul_i = 1'b1;
        start_i = 1'b0;
        @(posedge clk);
        #1;
        annul_i = 1'b0;
        checkOutput("annul_ready", {63'b0, ready_o}, 64'h0);
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("annul_idle", {63'b0, ready_o}, 64'h0);
        end
        applyStimulus(1'b0, 32'd20, 32'd3);
        waitReady("u20_3", 33, 64'h00000002_00000006, 1'b0);
        releaseStart("u20_3");

        // Reset in the middle of iteration 16 with start held high throughout.
        applyStimulus(1'b0, 32'd1000, 32'd7);
        @(posedge clk);
        repeat (16) @(posedge clk);
        #1;
        rst = 1'b1;
        repeat (2) begin
            @(posedge clk);
            #1;
            checkOutput("rst_mid_ready", {63'b0, ready_o}, 64'h0);
            checkOutput("rst_mid_result", result_o, 64'h0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 32'd50, 32'd5);
        waitReady("u50_5_scrambled", 33, 64'h00000000_0000000A, 1'b1);
        releaseStart("u50_5");

        repeat (2) @(posedge clk);
        #1;
        chkEn = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
